// File: rtl/wav_mcuintf_msg_ctrl.sv
// rtl/wav_mcuintf_msg_ctrl.sv - mailbox req/ack handshake tracker with sticky events and irqs

// One mailbox channel: 4-phase req/ack FSM, payload capture and per-phase timeout
module wav_mcuintf_msg_ch #(
  parameter int DWIDTH  = 32,
  parameter int IDWIDTH = 32,
  parameter int TOW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DWIDTH-1:0]  data,
  input  logic [IDWIDTH-1:0] id,
  input  logic               req,
  input  logic               ack,
  input  logic [TOW-1:0]     timeout_cfg,
  output logic [DWIDTH-1:0]  data_q,
  output logic [IDWIDTH-1:0] id_q,
  output logic [1:0]         state,
  output logic               req_evt,
  output logic               ack_evt,
  output logic               err_evt
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2, DONE = 2'd3} state_t;

  state_t         cur;
  state_t         nxt;
  logic [TOW-1:0] cnt;
  logic           capture;
  logic           timed_out;

  assign state = cur;

  // Next-state and event decode; a stalled phase that reaches the limit is forced back to IDLE
  always_comb begin
    nxt       = cur;
    req_evt   = 1'b0;
    ack_evt   = 1'b0;
    err_evt   = 1'b0;
    capture   = 1'b0;
    timed_out = 1'b0;
    case (cur)
      IDLE: begin
        if (req) begin
          nxt     = REQ;
          capture = 1'b1;
          req_evt = 1'b1;
        end else if (ack) begin
          err_evt = 1'b1;
        end
      end
      REQ: begin
        if (!req) begin
          nxt     = IDLE;
          err_evt = 1'b1;
        end else if (ack) begin
          nxt     = ACK;
          ack_evt = 1'b1;
        end
      end
      ACK: begin
        if (!req) nxt = DONE;
      end
      DONE: begin
        if (!ack) nxt = IDLE;
        else if (req) err_evt = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if ((timeout_cfg != '0) && (cur != IDLE) && (nxt == cur) &&
        (cnt == timeout_cfg - TOW'(1))) begin
      timed_out = 1'b1;
      err_evt   = 1'b1;
      nxt       = IDLE;
    end
  end

  // State, phase counter and payload registers; payload only reloads on a new request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur    <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else begin
      cur <= nxt;
      if ((nxt != cur) || (cur == IDLE) || timed_out) cnt <= '0;
      else if (cnt != '1) cnt <= cnt + TOW'(1);
      if (capture) begin
        data_q <= data;
        id_q   <= id;
      end
    end
  end

endmodule

// Top: two independent channels, shared sticky status and maskable interrupts
module wav_mcuintf_msg_ctrl #(
  parameter int DWIDTH  = 32,
  parameter int IDWIDTH = 32,
  parameter int TOW     = 16
) (
  input  logic               i_hclk,
  input  logic               i_hreset,
  input  logic [DWIDTH-1:0]  i_h2m_data,
  input  logic [IDWIDTH-1:0] i_h2m_id,
  input  logic               i_h2m_req,
  input  logic               i_h2m_ack,
  input  logic [DWIDTH-1:0]  i_m2h_data,
  input  logic [IDWIDTH-1:0] i_m2h_id,
  input  logic               i_m2h_req,
  input  logic               i_m2h_ack,
  input  logic [TOW-1:0]     i_timeout_cfg,
  input  logic [5:0]         i_evt_clr,
  input  logic [5:0]         i_mcu_irq_en,
  input  logic [5:0]         i_host_irq_en,
  output logic [DWIDTH-1:0]  o_h2m_data_q,
  output logic [IDWIDTH-1:0] o_h2m_id_q,
  output logic [DWIDTH-1:0]  o_m2h_data_q,
  output logic [IDWIDTH-1:0] o_m2h_id_q,
  output logic [1:0]         o_h2m_state,
  output logic [1:0]         o_m2h_state,
  output logic [5:0]         o_evt_status,
  output logic               o_mcu_irq,
  output logic               o_host_irq
);

  logic h2m_req_evt, h2m_ack_evt, h2m_err_evt;
  logic m2h_req_evt, m2h_ack_evt, m2h_err_evt;
  logic [5:0] evt_set;

  wav_mcuintf_msg_ch #(.DWIDTH(DWIDTH), .IDWIDTH(IDWIDTH), .TOW(TOW)) u_h2m (
    .clk(i_hclk), .rst(i_hreset),
    .data(i_h2m_data), .id(i_h2m_id), .req(i_h2m_req), .ack(i_h2m_ack),
    .timeout_cfg(i_timeout_cfg),
    .data_q(o_h2m_data_q), .id_q(o_h2m_id_q), .state(o_h2m_state),
    .req_evt(h2m_req_evt), .ack_evt(h2m_ack_evt), .err_evt(h2m_err_evt)
  );

  wav_mcuintf_msg_ch #(.DWIDTH(DWIDTH), .IDWIDTH(IDWIDTH), .TOW(TOW)) u_m2h (
    .clk(i_hclk), .rst(i_hreset),
    .data(i_m2h_data), .id(i_m2h_id), .req(i_m2h_req), .ack(i_m2h_ack),
    .timeout_cfg(i_timeout_cfg),
    .data_q(o_m2h_data_q), .id_q(o_m2h_id_q), .state(o_m2h_state),
    .req_evt(m2h_req_evt), .ack_evt(m2h_ack_evt), .err_evt(m2h_err_evt)
  );

  assign evt_set = {m2h_err_evt, m2h_ack_evt, m2h_req_evt,
                    h2m_err_evt, h2m_ack_evt, h2m_req_evt};

  // Sticky status (a new event beats a same-cycle clear); irqs lag status by one cycle
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      o_evt_status <= '0;
      o_mcu_irq    <= 1'b0;
      o_host_irq   <= 1'b0;
    end else begin
      o_evt_status <= (o_evt_status & ~i_evt_clr) | evt_set;
      o_mcu_irq    <= |(o_evt_status & i_mcu_irq_en);
      o_host_irq   <= |(o_evt_status & i_host_irq_en);
    end
  end

endmodule

// File: doc/wav_mcuintf_msg_ctrl.md
# wav_mcuintf_msg_ctrl

Mailbox handshake controller that sits directly downstream of the MCU interface CSR block. It consumes the host-to-MCU and MCU-to-host message data/id/req/ack register outputs, tracks each channel's 4-phase req/ack handshake, and captures message payloads on request. It also flags protocol errors and timeouts, and raises maskable interrupts toward the MCU and the host.

## Interface
- DWIDTH, 32, message data width
- IDWIDTH, 32, message id width
- TOW, 16, timeout counter width
- i_hclk  in  1  clock (same domain as CSR block)
- i_hreset  in  1  reset, asynchronous, active-high
- i_h2m_data / i_h2m_id  in  DWIDTH / IDWIDTH  host2mcu msg data/id from CSR
- i_h2m_req / i_h2m_ack  in  1 / 1  host2mcu req/ack from CSR (bit 0 of CSR field)
- i_m2h_data / i_m2h_id  in  DWIDTH / IDWIDTH  mcu2host msg data/id from CSR
- i_m2h_req / i_m2h_ack  in  1 / 1  mcu2host req/ack from CSR
- i_timeout_cfg  in  TOW  cycles allowed per handshake phase; 0 disables timeout
- i_evt_clr  in  6  write-1-to-clear pulse per status bit
- i_mcu_irq_en / i_host_irq_en  in  6 / 6  interrupt enables per status bit
- o_h2m_data_q / o_h2m_id_q  out  DWIDTH / IDWIDTH  host2mcu payload captured at request
- o_m2h_data_q / o_m2h_id_q  out  DWIDTH / IDWIDTH  mcu2host payload captured at request
- o_h2m_state / o_m2h_state  out  2 / 2  channel FSM state
- o_evt_status  out  6  sticky {m2h_err, m2h_ack, m2h_req, h2m_err, h2m_ack, h2m_req}
- o_mcu_irq / o_host_irq  out  1 / 1  registered interrupts

## Operation
- The two channels are identical, independent FSM instances. All inputs are already synchronous to i_hclk, so no synchronizers are used.
- States: IDLE=0, REQ=1, ACK=2, DONE=3. The FSM evaluates one transition per cycle, in the priority order listed below.
- IDLE:
  - req=1 -> REQ. Capture data and id into the *_q registers; set req_evt.
  - else ack=1 -> set err_evt; stay in IDLE.
- REQ:
  - req=0 -> set err_evt; go to IDLE (request withdrawn before ack).
  - else ack=1 -> ACK; set ack_evt.
- ACK:
  - req=0 -> DONE.
- DONE:
  - ack=0 -> IDLE.
  - else req=1 -> set err_evt; stay in DONE.
- Simultaneous req and ack rising in IDLE: take IDLE->REQ only. Ack is evaluated in REQ on the next cycle and is not an error.
- Timeout:
  - Per-channel counter clears on every state change and while in IDLE; otherwise it increments and saturates at all-ones.
  - When i_timeout_cfg != 0 and counter == i_timeout_cfg-1 in a non-IDLE state with no transition that cycle: set err_evt, force IDLE, clear counter.
- Captured payload holds until the next IDLE->REQ transition. It is not cleared by errors.
- Status bits:
  - Sticky; cleared by the matching i_evt_clr bit.
  - A set in the same cycle as a clear wins (bit stays 1).
- Interrupts: o_mcu_irq <= |(o_evt_status & i_mcu_irq_en); o_host_irq likewise with i_host_irq_en.

## Timing
- Reset values: states=IDLE, all *_q=0, o_evt_status=0, irqs=0, counters=0.
- An input change sampled at clock edge N updates state, *_q and status at edge N. The irq reflects it at edge N+1, so the irq is visible 2 cycles after the input changes.
- The irq deasserts 1 cycle after the status bit clears or its enable drops.
- Assertion of i_hreset mid-handshake returns everything to reset values immediately. After release, a still-high req is treated as a new request on the first edge.
- Timeout semantics: with cfg=T, the forced IDLE occurs at the T-th edge spent in the same non-IDLE state.

## Test plan
- Clean h2m handshake:
  - Stimulus: data=0xA5A5_0001, id=0x7; req 0->1, ack 0->1, req 1->0, ack 1->0 at 3-cycle spacing; mcu_irq_en=6'b000001.
  - Response: state sequence 0,1,2,3,0; o_h2m_data_q=0xA5A5_0001; status=6'b000011; o_mcu_irq high 1 cycle after req_evt.
- Protocol errors:
  - Stimulus: m2h ack=1 while IDLE; then req pulse without ack.
  - Response: status bit5 set each time; o_m2h_state returns to 0; o_host_irq asserts if en[5]=1.
- Timeout:
  - Stimulus: cfg=4; h2m req=1, ack held 0.
  - Response: REQ held 4 edges, then IDLE with bit2 set. With cfg=0 the FSM stays in REQ indefinitely.
- Set/clear collision:
  - Stimulus: i_evt_clr[0]=1 on the same edge as a new h2m request.
  - Response: bit0 remains 1.
- Simultaneous req+ack and reset mid-op:
  - Stimulus: req and ack rise together; then reset asserted in ACK.
  - Response: IDLE->REQ->ACK with no error; on reset all outputs return to 0 asynchronously. After release with req=1, REQ is re-entered and payload recaptured.
